pipe_reg: RTL and testbench

- Parametrised successor to the team's single-stage async-reset data register.
- Implements a DEPTH-stage, WIDTH-bit register pipeline with a valid/ready handshake on both sides, bubble collapsing, synchronous flush, a programmable reset value and an occupancy count.
- Used as the standard retiming and decoupling stage between datapath blocks.
- Sustains one transfer per cycle.

---
 rtl/pipe_reg.sv | 118 +++++++++++
 tb/tb_pipe_reg.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage, WIDTH-bit register pipeline with valid/ready
// handshakes on both sides, bubble collapsing, synchronous flush, a
// programmable reset value and a registered occupancy count.
module pipe_reg #(
   parameter int unsigned      WIDTH     = 4,
   parameter int unsigned      DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       n_reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);

   // Stage state: valid bits, data registers and occupancy.
   logic [DEPTH-1:0] v_q, v_d;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];
   logic [CW-1:0]    count_q, count_d;

   // Advance chain: ld_ext[k] says stage k may load this edge; the extra
   // top entry stands for the downstream consumer.
   logic [DEPTH:0]   ld_ext;
   logic [DEPTH-1:0] mv;

   // What each stage would load from: stage 0 from the input port,
   // stage k from stage k-1.
   logic [DEPTH-1:0] up_v;
   logic [WIDTH-1:0] up_d [DEPTH];

   logic in_xfer;
   logic out_xfer;

   // Ready chain, evaluated from the output stage back to the input stage.
   always_comb begin
      // NOTE: every variable in a combinational block gets a default first,
      // so no path leaves it unassigned and no latch is inferred.
      mv             = '0;
      ld_ext         = '0;
      ld_ext[DEPTH]  = out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         mv[k]     = v_q[k] & ld_ext[k+1];
         ld_ext[k] = !v_q[k] | mv[k];
      end
   end

   // Upstream view of every stage.
   always_comb begin
      up_v    = '0;
      up_d[0] = in_data;
      up_v[0] = in_valid;
      for (int k = 1; k < DEPTH; k++) begin
         up_v[k] = v_q[k-1];
         up_d[k] = d_q[k-1];
      end
   end

   // Port-side handshake signals; flush blocks transfers on both sides.
   always_comb begin
      in_ready  = ld_ext[0] & !flush;
      out_valid = v_q[DEPTH-1] & !flush;
      out_data  = d_q[DEPTH-1];
      count     = count_q;
      in_xfer   = in_valid & in_ready;
      out_xfer  = out_valid & out_ready;
   end

   // Next-state: flush clears valids and count; otherwise loading stages
   // take their upstream valid, and data only when that upstream is valid.
   always_comb begin
      v_d     = v_q;
      d_d     = d_q;
      count_d = count_q;
      if (flush) begin
         v_d     = '0;
         count_d = '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (ld_ext[k]) begin
               v_d[k] = up_v[k];
               if (up_v[k]) begin
                  d_d[k] = up_d[k];
               end
            end
         end
         count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         v_q     <= '0;
         count_q <= '0;
         // NOTE: the data stages are reset too because the reset value is
         // architecturally visible on out_data; plain storage arrays
         // normally stay unreset.
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= RESET_VAL;
         end
      end else begin
         // NOTE: non-blocking assignments here, so every flop samples the
         // pre-edge values regardless of statement order.
         v_q     <= v_d;
         d_q     <= d_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: self-checking bench for pipe_reg (WIDTH=8, DEPTH=3).
// Reference model: a FIFO of accepted words, each tagged with the cycle it
// was accepted; the oldest word is visible once it has aged DEPTH-1 edges.
module tb_pipe_reg;

   localparam int         WIDTH = 8;
   localparam int         DEPTH = 3;
   localparam logic [7:0] RV    = 8'hA5;
   localparam int         CW    = $clog2(DEPTH + 1);

   typedef logic [WIDTH+CW+1:0] vec_t;
   typedef struct {
      logic [7:0] d;
      int         t;
   } entry_t;

   logic          clk = 1'b0;
   logic          n_reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          flush = 1'b0;
   logic [7:0]    in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [7:0]    out_data;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .count     (count)
   );

   entry_t     q[$];
   logic [7:0] last_d = RV;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   logic       exp_ir, exp_ov, last_in_x, last_out_x;
   logic [7:0] exp_od;
   logic [CW-1:0] exp_cnt;

   function automatic vec_t obs_vec();
      return {in_ready, out_valid, out_data, count};
   endfunction

   function automatic vec_t exp_vec();
      return {exp_ir, exp_ov, exp_od, exp_cnt};
   endfunction

   // Drive inputs (called just after a falling edge) and predict outputs.
   task automatic apply(input logic iv, input logic [7:0] id,
                        input logic ordy, input logic fl);
      logic head_vis;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      #1;
      head_vis = (q.size() > 0) && (cyc - q[0].t >= DEPTH - 1);
      if (head_vis) last_d = q[0].d;
      exp_ov  = !fl && head_vis;
      exp_ir  = !fl && ((q.size() < DEPTH) || ordy);
      exp_od  = last_d;
      exp_cnt = CW'(q.size());
   endtask

   // Cross the rising edge and update the model with the transfers made.
   task automatic advance();
      last_out_x = exp_ov && out_ready;
      last_in_x  = exp_ir && in_valid;
      @(posedge clk);
      if (flush) begin
         q.delete();
      end else begin
         if (last_out_x) void'(q.pop_front());
         if (last_in_x) q.push_back('{d: in_data, t: cyc + 1});
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 n_reset = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h3C;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if ({in_ready, out_valid, out_data, count} !== {1'b1, 1'b0, RV, CW'(0)}) begin
            bad++;
            $display("FAIL reset got ir=%b ov=%b od=%h cnt=%0d want ir=1 ov=0 od=%h cnt=0",
                     in_ready, out_valid, out_data, count, RV);
         end
      end
      n_reset  = 1'b1;
      in_valid = 1'b0;
      q.delete();
      last_d = RV;
   endtask

   task automatic test_stream();
      int acc_cyc = -1;
      int seen_cyc = -1;
      for (int i = 0; i < 10; i++) begin
         apply(i < 4, 8'(i + 1), 1'b1, 1'b0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL stream cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         if (out_valid && out_data == 8'h01 && seen_cyc < 0) seen_cyc = cyc;
         advance();
         if (i == 0 && last_in_x) acc_cyc = cyc;
      end
      total++;
      if (acc_cyc < 0 || seen_cyc - acc_cyc != DEPTH - 1) begin
         bad++;
         $display("FAIL stream_latency got=%0d want=%0d", seen_cyc - acc_cyc, DEPTH - 1);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] words[4] = '{8'h10, 8'h11, 8'h12, 8'h13};
      logic [7:0] got[$];
      int idx = 0;
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, words[idx], 1'b0, 1'b0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL bp_fill cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         advance();
         if (last_in_x) idx++;
      end
      apply(1'b1, words[idx], 1'b0, 1'b0);
      total++;
      if ({in_ready, out_valid, out_data, count} !== {1'b0, 1'b1, 8'h10, CW'(DEPTH)} || idx != 3) begin
         bad++;
         $display("FAIL bp_full got ir=%b ov=%b od=%h cnt=%0d acc=%0d want ir=0 ov=1 od=10 cnt=3 acc=3",
                  in_ready, out_valid, out_data, count, idx);
      end
      for (int i = 0; i < 20 && (idx < 4 || q.size() > 0); i++) begin
         apply(idx < 4, words[idx < 4 ? idx : 3], 1'b1, 1'b0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL bp_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         if (out_valid) got.push_back(out_data);
         advance();
         if (last_in_x) idx++;
      end
      total++;
      if (got.size() != 4 || got[0] !== 8'h10 || got[1] !== 8'h11 ||
          got[2] !== 8'h12 || got[3] !== 8'h13) begin
         bad++;
         $display("FAIL bp_order got %0d words first=%h want 10,11,12,13",
                  got.size(), got.size() > 0 ? got[0] : 8'h00);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
         advance();
      end
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
         total++;
         if (obs_vec() !== exp_vec() || !in_ready || !out_valid || count !== CW'(DEPTH)) begin
            bad++;
            $display("FAIL b2b cyc=%0d got=%h want=%h (ir=1 ov=1 cnt=3)", cyc, obs_vec(), exp_vec());
         end
         advance();
      end
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL b2b_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         advance();
      end
   endtask

   task automatic test_flush();
      apply(1'b1, 8'h61, 1'b0, 1'b0);
      advance();
      apply(1'b1, 8'h62, 1'b0, 1'b0);
      advance();
      apply(1'b1, 8'h77, 1'b0, 1'b1);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== CW'(2)) begin
         bad++;
         $display("FAIL flush_hs got ir=%b ov=%b cnt=%0d want ir=0 ov=0 cnt=2",
                  in_ready, out_valid, count);
      end
      advance();
      for (int i = 0; i < 6; i++) begin
         apply(1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (obs_vec() !== exp_vec() || out_valid !== 1'b0 || count !== CW'(0)) begin
            bad++;
            $display("FAIL flush_after cyc=%0d got=%h want=%h (ov=0 cnt=0)", cyc, obs_vec(), exp_vec());
         end
         advance();
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
         advance();
      end
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      total++;
      if (count !== CW'(DEPTH) || out_valid !== 1'b1 || out_data !== 8'h20) begin
         bad++;
         $display("FAIL areset_pre got ov=%b od=%h cnt=%0d want ov=1 od=20 cnt=3",
                  out_valid, out_data, count);
      end
      #2 n_reset = 1'b0;
      #1;
      total++;
      if ({out_valid, out_data, count} !== {1'b0, RV, CW'(0)}) begin
         bad++;
         $display("FAIL areset got ov=%b od=%h cnt=%0d want ov=0 od=%h cnt=0",
                  out_valid, out_data, count, RV);
      end
      @(posedge clk);
      @(negedge clk);
      n_reset = 1'b1;
      q.delete();
      last_d = RV;
      cyc++;
      for (int i = 0; i < 8; i++) begin
         apply(i < 4, 8'(8'h80 + i), 1'b1, 1'b0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL areset_after cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         advance();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         apply(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 19) == 0));
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_stream();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
